branch_resolve_unit: RTL and testbench

Resolution-side partner of the tournament branch predictor. Records each prediction issued at fetch in an in-order FIFO. When the execute stage resolves the oldest outstanding branch, the unit:
- produces the predictor/meta-predictor training signals (resolved outcome, branch address, which component was right);
- raises a mispredict redirect to fetch.

It sits between fetch (push side) and execute (resolve side).

---
 rtl/bru_pkg.sv | 16 +
 rtl/bru_fifo.sv | 61 ++++++
 rtl/branch_resolve_unit.sv | 143 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and default sizing for the branch resolve unit.
package bru_pkg;

   localparam int unsigned DefaultDepth = 4;
   localparam int unsigned DefaultAddrW = 32;

   // One in-flight prediction as recorded at fetch.
   typedef struct packed {
      logic [DefaultAddrW-1:0] addr;
      logic                    taken;
      logic                    global_dir;
      logic                    local_dir;
      logic [DefaultAddrW-1:0] alt_addr;
   } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// In-order synchronous FIFO of prediction records with push, pop and clear.
// Clear wins over push and pop; a push while full is ignored.
module bru_fifo
   import bru_pkg::*;
#(
   parameter int unsigned DEPTH   = DefaultDepth,
   parameter type         entry_t = bru_entry_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   input  logic                   clear,
   output entry_t                 head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

   entry_t          mem_q [DEPTH];
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push;
   logic            do_pop;

   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolution side of the tournament predictor: trains tables and redirects fetch on mispredict.
// Define BRU_STATS_EN to build the resolved/mispredict statistics counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int unsigned DEPTH  = DefaultDepth,
   parameter int unsigned ADDR_W = DefaultAddrW
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   Pred_valid,
   input  logic [ADDR_W-1:0]      Pred_addr,
   input  logic                   Pred_taken,
   input  logic                   Pred_global,
   input  logic                   Pred_local,
   input  logic [ADDR_W-1:0]      Pred_alt_addr,
   output logic                   Pred_ready,
   input  logic                   Resolve_valid,
   input  logic                   Resolve_taken,
   output logic                   Update_valid,
   output logic [ADDR_W-1:0]      Update_addr,
   output logic                   Update_taken,
   output logic                   Update_meta_valid,
   output logic                   Update_meta_global,
   output logic                   Mispredict,
   output logic [ADDR_W-1:0]      Redirect_addr,
   output logic [$clog2(DEPTH):0] Outstanding,
   output logic                   Resolve_underflow,
   output logic [31:0]            Stat_resolved,
   output logic [31:0]            Stat_mispredict
);

   // Same layout as bru_entry_t, sized by this instance's ADDR_W.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              taken;
      logic              global_dir;
      logic              local_dir;
      logic [ADDR_W-1:0] alt_addr;
   } entry_t;

   entry_t                 push_entry;
   entry_t                 head;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;
   logic                   resolve_hit;
   logic                   kill;
   logic                   push;

   logic                   update_valid_q;
   logic [ADDR_W-1:0]      update_addr_q;
   logic                   update_taken_q;
   logic                   meta_valid_q;
   logic                   meta_global_q;
   logic                   mispredict_q;
   logic [ADDR_W-1:0]      redirect_addr_q;
   logic                   underflow_q;

   assign push_entry = '{addr:       Pred_addr,
                         taken:      Pred_taken,
                         global_dir: Pred_global,
                         local_dir:  Pred_local,
                         alt_addr:   Pred_alt_addr};

   assign resolve_hit = Resolve_valid && !empty;
   assign kill        = resolve_hit && (head.taken != Resolve_taken);
   assign Pred_ready  = !full;
   assign push        = Pred_valid && Pred_ready && !kill;

   // A mispredict clears every younger wrong-path entry along with the head.
   bru_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (CLK),
      .reset     (RESET),
      .push      (push),
      .push_data (push_entry),
      .pop       (resolve_hit),
      .clear     (kill),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         update_valid_q  <= 1'b0;
         update_addr_q   <= '0;
         update_taken_q  <= 1'b0;
         meta_valid_q    <= 1'b0;
         meta_global_q   <= 1'b0;
         mispredict_q    <= 1'b0;
         redirect_addr_q <= '0;
         underflow_q     <= 1'b0;
      end else begin
         update_valid_q <= resolve_hit;
         meta_valid_q   <= resolve_hit && (head.global_dir != head.local_dir);
         mispredict_q   <= kill;
         if (resolve_hit) begin
            update_addr_q   <= head.addr;
            update_taken_q  <= Resolve_taken;
            meta_global_q   <= (head.global_dir == Resolve_taken);
            redirect_addr_q <= head.alt_addr;
         end
         if (Resolve_valid && empty) underflow_q <= 1'b1;
      end
   end

   assign Update_valid       = update_valid_q;
   assign Update_addr        = update_addr_q;
   assign Update_taken       = update_taken_q;
   assign Update_meta_valid  = meta_valid_q;
   assign Update_meta_global = meta_global_q;
   assign Mispredict         = mispredict_q;
   assign Redirect_addr      = redirect_addr_q;
   assign Outstanding        = count;
   assign Resolve_underflow  = underflow_q;

`ifdef BRU_STATS_EN
   logic [31:0] stat_resolved_q;
   logic [31:0] stat_mispredict_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stat_resolved_q   <= '0;
         stat_mispredict_q <= '0;
      end else begin
         if (resolve_hit) stat_resolved_q   <= stat_resolved_q + 32'd1;
         if (kill)        stat_mispredict_q <= stat_mispredict_q + 32'd1;
      end
   end

   assign Stat_resolved   = stat_resolved_q;
   assign Stat_mispredict = stat_mispredict_q;
`else
   assign Stat_resolved   = '0;
   assign Stat_mispredict = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed test-plan steps, then random traffic
// checked against a queue-based model of the prediction FIFO.
module tb_branch_resolve_unit;

   localparam int unsigned Depth = 4;
   localparam int unsigned AddrW = 32;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             Pred_valid;
   logic [AddrW-1:0] Pred_addr;
   logic             Pred_taken;
   logic             Pred_global;
   logic             Pred_local;
   logic [AddrW-1:0] Pred_alt_addr;
   logic             Pred_ready;
   logic             Resolve_valid;
   logic             Resolve_taken;
   logic             Update_valid;
   logic [AddrW-1:0] Update_addr;
   logic             Update_taken;
   logic             Update_meta_valid;
   logic             Update_meta_global;
   logic             Mispredict;
   logic [AddrW-1:0] Redirect_addr;
   logic [2:0]       Outstanding;
   logic             Resolve_underflow;
   logic [31:0]      Stat_resolved;
   logic [31:0]      Stat_mispredict;

   branch_resolve_unit #(
      .DEPTH  (Depth),
      .ADDR_W (AddrW)
   ) dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .Pred_valid         (Pred_valid),
      .Pred_addr          (Pred_addr),
      .Pred_taken         (Pred_taken),
      .Pred_global        (Pred_global),
      .Pred_local         (Pred_local),
      .Pred_alt_addr      (Pred_alt_addr),
      .Pred_ready         (Pred_ready),
      .Resolve_valid      (Resolve_valid),
      .Resolve_taken      (Resolve_taken),
      .Update_valid       (Update_valid),
      .Update_addr        (Update_addr),
      .Update_taken       (Update_taken),
      .Update_meta_valid  (Update_meta_valid),
      .Update_meta_global (Update_meta_global),
      .Mispredict         (Mispredict),
      .Redirect_addr      (Redirect_addr),
      .Outstanding        (Outstanding),
      .Resolve_underflow  (Resolve_underflow),
      .Stat_resolved      (Stat_resolved),
      .Stat_mispredict    (Stat_mispredict)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] alt;
      bit          t;
      bit          g;
      bit          l;
   } ent_t;

   ent_t        mq[$];
   bit          m_uf;
   int unsigned m_res;
   int unsigned m_mis;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RESET         = 1'b1;
      Pred_valid    = 1'b0;
      Pred_addr     = '0;
      Pred_taken    = 1'b0;
      Pred_global   = 1'b0;
      Pred_local    = 1'b0;
      Pred_alt_addr = '0;
      Resolve_valid = 1'b0;
      Resolve_taken = 1'b0;
      @(posedge CLK);
      #1;
      chk("rst_ready", Pred_ready, 1);
      chk("rst_outstanding", Outstanding, 0);
      chk("rst_update_valid", Update_valid, 0);
      chk("rst_update_addr", Update_addr, 0);
      chk("rst_update_taken", Update_taken, 0);
      chk("rst_meta_valid", Update_meta_valid, 0);
      chk("rst_meta_global", Update_meta_global, 0);
      chk("rst_mispredict", Mispredict, 0);
      chk("rst_redirect", Redirect_addr, 0);
      chk("rst_underflow", Resolve_underflow, 0);
      chk("rst_stat_resolved", Stat_resolved, 0);
      chk("rst_stat_mispredict", Stat_mispredict, 0);
      RESET = 1'b0;
      mq.delete();
      m_uf  = 1'b0;
      m_res = 0;
      m_mis = 0;
   endtask

   // Drive one cycle of stimulus, advance the model, and compare every output.
   task automatic cycle(input bit pv, input logic [31:0] a, input bit t, input bit g,
                        input bit l, input logic [31:0] alt_a, input bit rv, input bit rt);
      ent_t        h;
      bit          hit;
      bit          mis;
      bit          psh;
      int unsigned exp_res;
      int unsigned exp_mis;
      Pred_valid    = pv;
      Pred_addr     = a;
      Pred_taken    = t;
      Pred_global   = g;
      Pred_local    = l;
      Pred_alt_addr = alt_a;
      Resolve_valid = rv;
      Resolve_taken = rt;
      hit = rv && (mq.size() > 0);
      if (hit) h = mq[0];
      mis = hit && (h.t != rt);
      psh = pv && (mq.size() < Depth) && !mis;
      if (rv && !hit) m_uf = 1'b1;
      @(posedge CLK);
      #1;
      if (mis) begin
         mq.delete();
      end else begin
         if (hit) void'(mq.pop_front());
         if (psh) mq.push_back('{addr: a, alt: alt_a, t: t, g: g, l: l});
      end
      if (hit) m_res++;
      if (mis) m_mis++;
`ifdef BRU_STATS_EN
      exp_res = m_res;
      exp_mis = m_mis;
`else
      exp_res = 0;
      exp_mis = 0;
`endif
      chk("update_valid", Update_valid, hit);
      chk("mispredict", Mispredict, mis);
      chk("meta_valid", Update_meta_valid, hit && (h.g != h.l));
      if (hit) begin
         chk("update_addr", Update_addr, h.addr);
         chk("update_taken", Update_taken, rt);
         chk("meta_global", Update_meta_global, h.g == rt);
      end
      if (mis) chk("redirect_addr", Redirect_addr, h.alt);
      chk("outstanding", Outstanding, mq.size());
      chk("pred_ready", Pred_ready, mq.size() < Depth);
      chk("underflow", Resolve_underflow, m_uf);
      chk("stat_resolved", Stat_resolved, exp_res);
      chk("stat_mispredict", Stat_mispredict, exp_mis);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit pv;
      bit rv;
      bit rt;
      bit tk;
      int unsigned exp_r;
      int unsigned exp_m;

      do_reset();

      // Fill to capacity, then try a fifth push.
      for (int i = 0; i < 4; i++) cycle(1, 32'h10 * i, i % 2, 0, 1, 32'h1000 + i, 0, 0);
      chk("full_outstanding", Outstanding, 4);
      chk("full_ready", Pred_ready, 0);
      cycle(1, 32'hdead, 1, 1, 1, 32'hbeef, 0, 0);
      chk("drop_outstanding", Outstanding, 4);
      // Drain with correct outcomes.
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, i % 2);
      chk("drained", Outstanding, 0);

      // Correct prediction with global/local disagreement.
      cycle(1, 32'h100, 1, 1, 0, 32'h104, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 1);
      chk("tp_update_addr", Update_addr, 32'h100);
      chk("tp_meta_global", Update_meta_global, 1);
      chk("tp_no_mispredict", Mispredict, 0);

      // Mispredict flushes younger entries and discards a coincident push.
      cycle(1, 32'h200, 0, 0, 0, 32'h240, 0, 0);
      cycle(1, 32'h204, 1, 1, 1, 32'h300, 0, 0);
      cycle(1, 32'h208, 0, 1, 0, 32'h400, 0, 0);
      cycle(1, 32'h20c, 1, 0, 1, 32'h500, 1, 1);
      chk("tp_mispredict", Mispredict, 1);
      chk("tp_redirect", Redirect_addr, 32'h240);
      chk("tp_meta_valid", Update_meta_valid, 0);
      chk("tp_flush_outstanding", Outstanding, 0);
      idle();
      chk("tp_mispredict_pulse", Mispredict, 0);

      // Resolve with nothing outstanding.
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      chk("tp_underflow_no_update", Update_valid, 0);
      chk("tp_underflow_set", Resolve_underflow, 1);
      idle();
      idle();
      chk("tp_underflow_held", Resolve_underflow, 1);
      do_reset();

      // Ten resolves, the first three mispredicting.
      for (int i = 0; i < 10; i++) begin
         tk = (i % 3) == 0;
         cycle(1, 32'h800 + 4 * i, tk, 1, 0, 32'h900 + 4 * i, 0, 0);
         cycle(0, 0, 0, 0, 0, 0, 1, (i < 3) ? !tk : tk);
      end
`ifdef BRU_STATS_EN
      exp_r = 10;
      exp_m = 3;
`else
      exp_r = 0;
      exp_m = 0;
`endif
      chk("tp_stat_resolved", Stat_resolved, exp_r);
      chk("tp_stat_mispredict", Stat_mispredict, exp_m);

      // Random traffic, with one reset mid-stream.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         pv = $urandom_range(99) < 60;
         rv = $urandom_range(99) < 45;
         if (mq.size() > 0 && $urandom_range(3) != 0) rt = mq[0].t;
         else rt = $urandom_range(1);
         cycle(pv, $urandom, $urandom_range(1), $urandom_range(1), $urandom_range(1),
               $urandom, rv, rt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
